// File: rtl/upsampling_pixel_fetcher.sv
// upsampling_pixel_fetcher
// Reads a row-major IMG_W x IMG_H image from a synchronous read memory and
// streams it over a valid/ready handshake to the upsampler. It also supplies
// the column and row of the current pixel, and a frame-done pulse.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             begin a frame fetch (sampled only while idle)
//   mem_rden/addr     memory read request; mem_rdata returns one cycle later
//   pix_out/valid     FIFO head toward the upsampler; pix_ready accepts it
//   end_of_row        current pixel is the last column of its row
//   cnt_col/cnt_row   coordinates of the pixel on pix_out
//   busy              frame in progress
//   end_of_pixel      one-cycle pulse after the last pixel of the frame is accepted
module upsampling_pixel_fetcher #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              end_of_row,
    output logic [9:0]        cnt_col,
    output logic [8:0]        cnt_row,
    output logic              busy,
    output logic              end_of_pixel
);

    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [9:0]        LAST_COL  = 10'(IMG_W - 1);
    localparam logic [8:0]        LAST_ROW  = 9'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_r;
    logic              inflight_r;
    logic [DATA_W-1:0] fifo_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic [9:0]        col_r;
    logic [8:0]        row_r;
    logic              eop_r;

    logic              accept_s;
    logic              credit_s;
    logic              rden_s;
    logic              last_pix_s;
    logic              start_frame_s;

    // Handshake, credit and frame-boundary decodes
    always_comb begin
        accept_s      = (count_r != 2'd0) & pix_ready;
        // Slots already committed (stored + returning) minus the one leaving
        // this cycle; a new read is only allowed if a slot is guaranteed free.
        credit_s      = (({1'b0, count_r} + {2'b00, inflight_r}) - {2'b00, accept_s}) < 3'd2;
        rden_s        = (state_r == ISSUE) & credit_s;
        last_pix_s    = accept_s & (col_r == LAST_COL) & (row_r == LAST_ROW);
        start_frame_s = (state_r == IDLE) & start;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (rden_s && (addr_r == LAST_ADDR)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (last_pix_s) begin
                    state_s = FINISH;
                end else begin
                    state_s = DRAIN;
                end
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and read-address counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            inflight_r <= rden_s;
            if (start_frame_s) begin
                addr_r <= '0;
            end else if (rden_s) begin
                addr_r <= (addr_r == LAST_ADDR) ? '0 : addr_r + 1'b1;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Two-entry FIFO: a returning read pushes, an accept pops; both may coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_r[0] <= '0;
            fifo_r[1] <= '0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            count_r   <= 2'd0;
        end else begin
            if (inflight_r) begin
                fifo_r[wr_ptr_r] <= mem_rdata;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (accept_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= (count_r + {1'b0, inflight_r}) - {1'b0, accept_s};
        end
    end

    // Pixel coordinates of the FIFO head and the frame-done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= 10'd0;
            row_r <= 9'd0;
            eop_r <= 1'b0;
        end else begin
            eop_r <= last_pix_s;
            if (start_frame_s) begin
                col_r <= 10'd0;
                row_r <= 9'd0;
            end else if (accept_s) begin
                if (col_r == LAST_COL) begin
                    col_r <= 10'd0;
                    row_r <= (row_r == LAST_ROW) ? 9'd0 : row_r + 9'd1;
                end else begin
                    col_r <= col_r + 10'd1;
                end
            end else begin
                col_r <= col_r;
                row_r <= row_r;
            end
        end
    end

    assign mem_rden     = rden_s;
    assign mem_addr     = addr_r;
    assign pix_out      = fifo_r[rd_ptr_r];
    assign pix_valid    = (count_r != 2'd0);
    assign end_of_row   = pix_valid & (col_r == LAST_COL);
    assign cnt_col      = col_r;
    assign cnt_row      = row_r;
    assign busy         = (state_r != IDLE);
    assign end_of_pixel = eop_r;

endmodule

// File: tb/tb_upsampling_pixel_fetcher.sv
module tb_upsampling_pixel_fetcher;

    localparam int MW = 10;
    localparam int MH = 3;
    localparam int MN = MW * MH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // medium-size instance (10 x 3)
    logic       m_start = 1'b0, m_ready = 1'b0;
    logic       m_rden, m_valid, m_eor, m_busy, m_eop;
    logic [4:0] m_addr;
    logic [7:0] m_rdata = 8'd0, m_pix;
    logic [9:0] m_col;
    logic [8:0] m_row;

    // small instance (4 x 2)
    logic       s_start = 1'b0, s_ready = 1'b0;
    logic       s_rden, s_valid, s_eor, s_busy, s_eop;
    logic [2:0] s_addr;
    logic [7:0] s_rdata = 8'd0, s_pix;
    logic [9:0] s_col;
    logic [8:0] s_row;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic logic [7:0] pix_of(input int a);
        return 8'((a * 37 + 5) & 255);
    endfunction

    upsampling_pixel_fetcher #(.IMG_W(MW), .IMG_H(MH), .DATA_W(8), .ADDR_W(5)) dut_m (
        .clk(clk), .rst(rst), .start(m_start),
        .mem_rden(m_rden), .mem_addr(m_addr), .mem_rdata(m_rdata),
        .pix_out(m_pix), .pix_valid(m_valid), .pix_ready(m_ready),
        .end_of_row(m_eor), .cnt_col(m_col), .cnt_row(m_row),
        .busy(m_busy), .end_of_pixel(m_eop)
    );

    upsampling_pixel_fetcher #(.IMG_W(4), .IMG_H(2), .DATA_W(8), .ADDR_W(3)) dut_s (
        .clk(clk), .rst(rst), .start(s_start),
        .mem_rden(s_rden), .mem_addr(s_addr), .mem_rdata(s_rdata),
        .pix_out(s_pix), .pix_valid(s_valid), .pix_ready(s_ready),
        .end_of_row(s_eor), .cnt_col(s_col), .cnt_row(s_row),
        .busy(s_busy), .end_of_pixel(s_eop)
    );

    // synchronous-read memory models
    always @(posedge clk) begin
        if (m_rden) m_rdata <= pix_of(int'(m_addr));
        if (s_rden) s_rdata <= pix_of(int'(s_addr));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_m_all_zero(input string tag);
        chk({tag, ".rden"},  int'(m_rden),  0);
        chk({tag, ".addr"},  int'(m_addr),  0);
        chk({tag, ".valid"}, int'(m_valid), 0);
        chk({tag, ".pix"},   int'(m_pix),   0);
        chk({tag, ".eor"},   int'(m_eor),   0);
        chk({tag, ".col"},   int'(m_col),   0);
        chk({tag, ".row"},   int'(m_row),   0);
        chk({tag, ".busy"},  int'(m_busy),  0);
        chk({tag, ".eop"},   int'(m_eop),   0);
    endtask

    // One frame on the medium instance with a cycle-by-cycle scoreboard.
    // rnd: random pix_ready with a 10-cycle low window; poke: pulse start mid-frame.
    task automatic run_frame(input bit rnd, input bit poke);
        int issued = 0, acc = 0, eops = 0;
        int first_rden = -1, first_valid = -1, eop_cyc = -1, last_acc = -10;
        bit prev_stall = 1'b0;
        logic [7:0] prev_pix = 8'd0;
        bit done = 1'b0;
        bit accept;
        @(negedge clk);
        m_start = 1'b1;
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        chk("frame.idle_busy", int'(m_busy), 0);
        chk("frame.idle_rden", int'(m_rden), 0);
        @(posedge clk);
        for (int cyc = 1; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            m_start = poke && (cyc == 5 || cyc == MN + 1);
            if (rnd) m_ready = (cyc >= 8 && cyc <= 17) ? 1'b0 : 1'($urandom_range(0, 1));
            else     m_ready = 1'b1;
            #1;
            accept = m_valid & m_ready;
            chk("frame.outstanding_le2", int'((issued - acc) <= 2), 1);
            if (m_rden) begin
                chk("frame.addr", int'(m_addr), issued);
                if (first_rden < 0) first_rden = cyc;
                issued++;
            end
            if (prev_stall) begin
                chk("frame.hold_valid", int'(m_valid), 1);
                chk("frame.hold_pix", int'(m_pix), int'(prev_pix));
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (accept) begin
                chk("frame.pix", int'(m_pix), int'(pix_of(acc)));
                chk("frame.col", int'(m_col), acc % MW);
                chk("frame.row", int'(m_row), acc / MW);
                chk("frame.eor", int'(m_eor), int'((acc % MW) == MW - 1));
                acc++;
                last_acc = cyc;
            end
            if (m_eop) begin
                eops++;
                if (eop_cyc < 0) eop_cyc = cyc;
                chk("frame.eop_after_last_accept", cyc, last_acc + 1);
                chk("frame.eop_all_accepted", acc, MN);
            end
            chk("frame.busy", int'(m_busy), int'(eop_cyc < 0 || cyc == eop_cyc));
            prev_stall = m_valid & ~m_ready;
            prev_pix   = m_pix;
            if (eop_cyc >= 0 && cyc >= eop_cyc + 4) done = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        m_start = 1'b0;
        chk("frame.terminated", int'(done), 1);
        chk("frame.issued", issued, MN);
        chk("frame.accepted", acc, MN);
        chk("frame.eop_count", eops, 1);
        if (!rnd) begin
            chk("frame.first_rden_cycle", first_rden, 1);
            chk("frame.first_valid_cycle", first_valid, 3);
            chk("frame.eop_cycle", eop_cyc, MN + 3);
        end
    endtask

    typedef struct {
        logic       st;
        logic       rdy;
        logic       rden;
        logic [2:0] addr;
        logic       valid;
        int         pidx;
        logic       eor;
        int         col;
        int         row;
        logic       busy;
        logic       eop;
    } vec_t;

    vec_t vt [14];

    initial begin
        // small frame: pix_ready low until the FIFO holds two pixels
        //          st    rdy   rden  addr  vld   pidx eor   col row busy  eop
        vt[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 0, 1'b0, 0, 0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 0, 1'b0, 0, 0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1, 1'b0, 1, 0, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 2, 1'b0, 2, 0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 3, 1'b1, 3, 0, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 4, 1'b0, 0, 1, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 5, 1'b0, 1, 1, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 6, 1'b0, 2, 1, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 7, 1'b1, 3, 1, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b1};
        vt[13] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0};

        // reset state
        #1;
        chk_m_all_zero("reset");
        chk("reset.s_valid", int'(s_valid), 0);
        chk("reset.s_busy", int'(s_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // full-rate frame, row boundaries, latency
        run_frame(1'b0, 1'b0);
        // random backpressure including a 10-cycle stall
        run_frame(1'b1, 1'b0);

        // asynchronous reset mid-frame
        @(negedge clk);
        m_start = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (12) @(negedge clk);
        chk("midframe.busy_before_reset", int'(m_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_m_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_m_all_zero("after_reset");
        // new frame must start again from address 0, column 0, row 0
        run_frame(1'b0, 1'b0);

        // start pulses during ISSUE and DRAIN are ignored
        run_frame(1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("post_frame.rden", int'(m_rden), 0);
            chk("post_frame.busy", int'(m_busy), 0);
            chk("post_frame.eop", int'(m_eop), 0);
        end

        // small-frame table
        for (int i = 0; i < 14; i++) begin
            bit ok;
            @(negedge clk);
            s_start = vt[i].st;
            s_ready = vt[i].rdy;
            #1;
            ok = (s_rden == vt[i].rden) && (s_addr == vt[i].addr) &&
                 (s_valid == vt[i].valid) &&
                 (!vt[i].valid || (s_pix == pix_of(vt[i].pidx))) &&
                 (s_eor == vt[i].eor) && (int'(s_col) == vt[i].col) &&
                 (int'(s_row) == vt[i].row) && (s_busy == vt[i].busy) &&
                 (s_eop == vt[i].eop);
            n_vec++;
            if (!ok) begin
                n_miss++;
                $display("FAIL small_vec[%0d]: got rden=%0d addr=%0d valid=%0d pix=%0d eor=%0d col=%0d row=%0d busy=%0d eop=%0d; expected rden=%0d addr=%0d valid=%0d pix=%0d eor=%0d col=%0d row=%0d busy=%0d eop=%0d",
                         i, s_rden, s_addr, s_valid, s_pix, s_eor, s_col, s_row, s_busy, s_eop,
                         vt[i].rden, vt[i].addr, vt[i].valid, pix_of(vt[i].pidx), vt[i].eor,
                         vt[i].col, vt[i].row, vt[i].busy, vt[i].eop);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
